// File: rtl/qam_demap_multi.sv
// qam_demap_multi: two-stage hard-decision BPSK/QPSK/16-QAM/64-QAM demapper with scaling and saturation.
// Optional saturation counter enabled by defining QAM_DEMAP_STATS_EN.
module qam_demap_multi #(
    parameter int DW     = 16,
    parameter int SHIFT  = 6,
    parameter int TH16   = 20724,
    parameter int TH64_2 = 10112,
    parameter int TH64_4 = 20225,
    parameter int TH64_6 = 30337
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [1:0]    s_mode,
    input  logic [DW-1:0] s_re,
    input  logic [DW-1:0] s_im,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [5:0]    m_bits,
    output logic [2:0]    m_nbits,
    output logic [15:0]   sat_cnt,
    input  logic          stat_clr
);
    localparam int XW = DW + SHIFT;
    localparam logic [DW-1:0] T16 = DW'(TH16);
    localparam logic [DW-1:0] T2  = DW'(TH64_2);
    localparam logic [DW-1:0] T4  = DW'(TH64_4);
    localparam logic [DW-1:0] T6  = DW'(TH64_6);

    // Returns {clip, sign, magnitude} of one rescaled, saturated component.
    function automatic logic [DW+1:0] scale(input logic [DW-1:0] s);
        logic [XW-1:0] x;
        logic [SHIFT:0] top;
        logic clip;
        logic [DW-1:0] v;
        logic [DW-1:0] a;
        x    = XW'($signed(s)) << SHIFT;
        top  = x[XW-1:DW-1];
        clip = !(&top || !(|top));
        v    = clip ? {x[XW-1], {(DW-1){!x[XW-1]}}} : x[DW-1:0];
        a    = !v[DW-1] ? v : (v[DW-2:0] == '0 ? {1'b0, {(DW-1){1'b1}}} : -v);
        return {clip, v[DW-1], a};
    endfunction

    logic          v1_q, v2_q, ld2;
    logic          sgn_i_q, sgn_q_q, clip1_q, clip2_q;
    logic [DW-1:0] a_i_q, a_q_q;
    logic [1:0]    mode1_q;
    logic [DW+1:0] sc_i_d, sc_q_d;
    logic [5:0]    bits_q, bits_d;
    logic [2:0]    nbits_q, nbits_d;

    assign ld2     = !v2_q || m_ready;
    assign s_ready = !v1_q || ld2;
    assign m_valid = v2_q;
    assign m_bits  = bits_q;
    assign m_nbits = nbits_q;

    // Rescale and saturate both components of the incoming symbol.
    always_comb begin
        sc_i_d = scale(s_re);
        sc_q_d = scale(s_im);
    end

    // Stage 1: capture sign, magnitude, mode and clip flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sgn_i_q <= 1'b0;
            sgn_q_q <= 1'b0;
            a_i_q   <= '0;
            a_q_q   <= '0;
            mode1_q <= 2'd0;
            clip1_q <= 1'b0;
        end else if (s_ready) begin
            v1_q <= s_valid;
            if (s_valid) begin
                sgn_i_q <= sc_i_d[DW];
                sgn_q_q <= sc_q_d[DW];
                a_i_q   <= sc_i_d[DW-1:0];
                a_q_q   <= sc_q_d[DW-1:0];
                mode1_q <= s_mode;
                clip1_q <= sc_i_d[DW+1] | sc_q_d[DW+1];
            end
        end
    end

    // Slice magnitudes against Gray-coded thresholds for the symbol's mode.
    always_comb begin
        bits_d  = mode1_q == 2'd0 ? {5'b0, sgn_i_q} :
                  mode1_q == 2'd1 ? {4'b0, sgn_q_q, sgn_i_q} :
                  mode1_q == 2'd2 ? {2'b0, a_q_q > T16, sgn_q_q, a_i_q > T16, sgn_i_q} :
                  {a_q_q > T2 && a_q_q <= T6, a_q_q > T4, sgn_q_q,
                   a_i_q > T2 && a_i_q <= T6, a_i_q > T4, sgn_i_q};
        nbits_d = mode1_q == 2'd0 ? 3'd1 : mode1_q == 2'd1 ? 3'd2 : mode1_q == 2'd2 ? 3'd4 : 3'd6;
    end

    // Stage 2: registered output, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            bits_q  <= '0;
            nbits_q <= '0;
            clip2_q <= 1'b0;
        end else if (ld2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                bits_q  <= bits_d;
                nbits_q <= nbits_d;
                clip2_q <= clip1_q;
            end
        end
    end

`ifdef QAM_DEMAP_STATS_EN
    logic [15:0] sat_q;
    assign sat_cnt = sat_q;

    // Count clipped symbols as they leave, saturating; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_q <= '0;
        else if (stat_clr) sat_q <= '0;
        else if (v2_q && m_ready && clip2_q && sat_q != 16'hFFFF) sat_q <= sat_q + 16'd1;
    end
`else
    logic unused_stats;
    assign unused_stats = ^{stat_clr, clip2_q};
    assign sat_cnt = '0;
`endif
endmodule

// File: tb/tb_qam_demap_multi.sv
// tb_qam_demap_multi: directed self-checking bench for qam_demap_multi.
module tb_qam_demap_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready, s_ready0;
    logic [1:0]  s_mode = 2'd0;
    logic [15:0] s_re = '0, s_im = '0;
    logic        m_valid, m_valid0;
    logic        m_ready = 1'b1;
    logic [5:0]  m_bits, m_bits0;
    logic [2:0]  m_nbits, m_nbits0;
    logic [15:0] sat_cnt, sat_cnt0;
    logic        stat_clr = 1'b0;
    int total = 0;
    int bad = 0;

    int vmd[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int vre[8]  = '{-10, 10, -400, -100, 0, -1, 324, -320};
    int vim[8]  = '{5, -10, 300, 480, -1, -1, -324, 160};
    int veb[8]  = '{6'b000001, 6'b000010, 6'b000011, 6'b010001, 6'b000000, 6'b000011, 6'b001110, 6'b100111};
    int venb[8] = '{1, 2, 4, 6, 1, 2, 4, 6};
    int rdy_pat[4] = '{1, 0, 0, 1};

    always #5 clk = ~clk;

    qam_demap_multi u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode),
        .s_re(s_re), .s_im(s_im), .m_valid(m_valid), .m_ready(m_ready), .m_bits(m_bits),
        .m_nbits(m_nbits), .sat_cnt(sat_cnt), .stat_clr(stat_clr)
    );

    qam_demap_multi #(.SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_mode(s_mode),
        .s_re(s_re), .s_im(s_im), .m_valid(m_valid0), .m_ready(m_ready), .m_bits(m_bits0),
        .m_nbits(m_nbits0), .sat_cnt(sat_cnt0), .stat_clr(stat_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int mode, input int re, input int im);
        s_valid = 1'b1;
        s_mode  = 2'(mode);
        s_re    = 16'(re);
        s_im    = 16'(im);
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("lat_early", 32'(m_valid), 32'(0));
        @(posedge clk); #1;
        chk("lat_valid", 32'(m_valid), 32'(1));
    endtask

    initial begin
        int in_idx, out_idx, inflight;
        logic held_v;
        logic [8:0] held;
        @(posedge clk); #1;
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_bits", 32'(m_bits), 32'(0));
        chk("rst_m_nbits", 32'(m_nbits), 32'(0));
        chk("rst_s_ready", 32'(s_ready), 32'(1));
        chk("rst_sat_cnt", 32'(sat_cnt), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        send(2, 400, -100);
        chk("qam16_bits", 32'(m_bits), 32'(6'b000110));
        chk("qam16_nbits", 32'(m_nbits), 32'(4));
        send(3, 200, -500);
        chk("qam64_bits", 32'(m_bits), 32'(6'b011100));
        chk("qam64_nbits", 32'(m_nbits), 32'(6));
        send(2, 600, -32768);
        chk("sat_bits", 32'(m_bits), 32'(6'b001110));
`ifdef QAM_DEMAP_STATS_EN
        chk("sat_cnt_pre", 32'(sat_cnt), 32'(0));
        @(posedge clk); #1;
        chk("sat_cnt_post", 32'(sat_cnt), 32'(1));
`endif

        send(2, 20724, 0);
        chk("th16_equal", 32'(m_bits0), 32'(6'b000000));
        chk("th16_equal_nb", 32'(m_nbits0), 32'(4));
        send(2, 20725, 0);
        chk("th16_above", 32'(m_bits0), 32'(6'b000010));
        @(posedge clk); #1;
`ifdef QAM_DEMAP_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        chk("stat_clr", 32'(sat_cnt), 32'(0));
`else
        chk("sat_cnt_off", 32'(sat_cnt), 32'(0));
`endif

        in_idx = 0; out_idx = 0; inflight = 0; held_v = 1'b0; held = '0;
        for (int c = 0; c < 60 && out_idx < 8; c++) begin
            @(posedge clk); #1;
            m_ready = rdy_pat[c % 4][0];
            s_valid = in_idx < 8;
            if (in_idx < 8) begin
                s_mode = 2'(vmd[in_idx]);
                s_re   = 16'(vre[in_idx]);
                s_im   = 16'(vim[in_idx]);
            end
            #3;
            if (held_v) begin
                chk("stall_valid", 32'(m_valid), 32'(1));
                chk("stall_hold", 32'({m_nbits, m_bits}), 32'(held));
            end
            chk("bp_s_ready", 32'(s_ready), 32'(!(inflight == 2 && !m_ready)));
            held_v = m_valid && !m_ready;
            held   = {m_nbits, m_bits};
            if (m_valid && m_ready) begin
                chk("bp_bits", 32'(m_bits), 32'(veb[out_idx]));
                chk("bp_nbits", 32'(m_nbits), 32'(venb[out_idx]));
                out_idx++;
                inflight--;
            end
            if (s_valid && s_ready) begin
                in_idx++;
                inflight++;
            end
        end
        chk("bp_count", 32'(out_idx), 32'(8));
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("bp_no_dup", 32'(m_valid), 32'(0));

        m_ready = 1'b0;
        s_valid = 1'b1; s_mode = 2'd1; s_re = 16'(100); s_im = 16'(100);
        @(posedge clk); #1;
        s_re = 16'(-100);
        @(posedge clk); #1;
        chk("full_m_valid", 32'(m_valid), 32'(1));
        chk("full_s_ready", 32'(s_ready), 32'(0));
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_m_valid", 32'(m_valid), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b1;
        chk("rst_rel_s_ready", 32'(s_ready), 32'(1));
        chk("rst_rel_m_valid", 32'(m_valid), 32'(0));
        send(0, -10, 0);
        chk("post_rst_bits", 32'(m_bits), 32'(6'b000001));
        chk("post_rst_nbits", 32'(m_nbits), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
